// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller.
// State encoding and counter sizing helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder; the only arithmetic in the serial adder.
// Purely combinational.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: LSB-first through one full adder.
// Optional subtract port enabled by SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  import serial_add_pkg::*;

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] s_sr;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] s_nxt;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

  full_adder u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (c),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  // s_nxt[0] is the first bit produced; only the last step reads it.
  assign s_nxt = {fa_sum, s_sr};

  always_comb begin
    b_ld = B;
    c_ld = Cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_ld = ~B;
      c_ld = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= b_ld;
            c     <= c_ld;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s_sr <= s_nxt[WIDTH-1:1];
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          c    <= fa_cout;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            Sum   <= s_nxt;
            Cout  <= fa_cout;
            ovf   <= c ^ fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
